// File: rtl/mux_pkg.sv
// Shared types for the time-shared MUX sequencer.
// Holds the controller state encoding and the default word width.
package mux_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux_word.sv
// One WIDTH-bit row of 2:1 MUX cells sharing a single select.
// F takes IN1 when SEL is high, otherwise IN0.
module mux_word
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] IN0,
  input  logic [WIDTH-1:0] IN1,
  input  logic             SEL,
  output logic [WIDTH-1:0] F
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign F[i] = SEL ? IN1[i] : IN0[i];
  end

endmodule

// File: rtl/mux_seq_ctrl.sv
// Sequencer selecting one of NUM_WORDS captured words by index,
// using one MUX row per cycle and an accumulator.
module mux_seq_ctrl
  import mux_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NUM_WORDS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH*NUM_WORDS-1:0] g_input,
  input  logic [IDX_W-1:0]           e_input,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           o
);

  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_WORDS - 1);

  state_t                     state;
  state_t                     state_nx;
  logic [IDX_W:0]             idx;
  logic [IDX_W-1:0]           sel_q;
  logic [WIDTH*NUM_WORDS-1:0] word_q;
  logic [WIDTH-1:0]           acc;
  logic [WIDTH-1:0]           cur_word;
  logic [WIDTH-1:0]           mux_f;
  logic                       hit;

  always_comb begin
    cur_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (idx == (IDX_W+1)'(k)) cur_word = word_q[k*WIDTH +: WIDTH];
    end
  end

  // idx is one bit wider than sel_q, so widen sel_q before comparing
  assign hit = ({1'b0, sel_q} == idx);

  mux_word #(.WIDTH(WIDTH)) u_mux (
    .IN0 (acc),
    .IN1 (cur_word),
    .SEL (hit),
    .F   (mux_f)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = (NUM_WORDS == 1) ? DONE : SCAN;
      end
      SCAN: begin
        if (idx == LAST) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      sel_q  <= '0;
      word_q <= '0;
      acc    <= '0;
      o      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            word_q <= g_input;
            sel_q  <= e_input;
            acc    <= g_input[WIDTH-1:0];
            idx    <= (IDX_W+1)'(1);
            if (NUM_WORDS == 1) o <= g_input[WIDTH-1:0];
          end
        end
        SCAN: begin
          acc <= mux_f;
          idx <= idx + 1'b1;
          if (idx == LAST) o <= mux_f;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mux_seq_ctrl.sv
// Bench for mux_seq_ctrl: 4-, 3- and 1-word instances checked
// against a word-selection model with latency and handshake checks.
module tb_mux_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start = '0;
  logic [31:0] g = '0;
  logic [1:0]  e = '0;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [7:0]  o4;
  logic [7:0]  o3;
  logic [7:0]  o1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mux_seq_ctrl #(.WIDTH(8), .NUM_WORDS(4), .IDX_W(2)) dut4 (
    .clk(clk), .rst(rst), .start(start[0]), .g_input(g),
    .e_input(e), .busy(busy_v[0]), .done(done_v[0]), .o(o4)
  );

  mux_seq_ctrl #(.WIDTH(8), .NUM_WORDS(3), .IDX_W(2)) dut3 (
    .clk(clk), .rst(rst), .start(start[1]), .g_input(g[23:0]),
    .e_input(e), .busy(busy_v[1]), .done(done_v[1]), .o(o3)
  );

  mux_seq_ctrl #(.WIDTH(8), .NUM_WORDS(1), .IDX_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[2]), .g_input(g[7:0]),
    .e_input(e[0]), .busy(busy_v[2]), .done(done_v[2]), .o(o1)
  );

  function automatic int nw(input int w);
    return (w == 0) ? 4 : ((w == 1) ? 3 : 1);
  endfunction

  // Reference: word e if it exists, otherwise word 0
  function automatic logic [7:0] ref_sel(input logic [31:0] gv,
                                         input int ev, input int n);
    if (ev < n) return 8'(gv >> (8 * ev));
    return gv[7:0];
  endfunction

  function automatic logic [7:0] o_of(input int w);
    return (w == 0) ? o4 : ((w == 1) ? o3 : o1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int w, input logic [31:0] gv,
                     input logic [1:0] ev, input bit pert,
                     input string tag);
    int         n;
    bit         seen;
    logic [7:0] exp;
    exp = ref_sel(gv, (w == 2) ? int'(ev[0]) : int'(ev), nw(w));
    g = gv;
    e = ev;
    start[w] = 1'b1;
    tick();
    start[w] = 1'b0;
    seen = 1'b0;
    n = 1;
    while (!seen && n <= 12) begin
      if (done_v[w]) begin
        seen = 1'b1;
      end else begin
        chk({tag, "_busy"}, 32'(busy_v[w]), 32'd1);
        if (pert && n == 1) begin
          g = 32'hFFFF_FFFF;
          e = 2'd1;
        end
        if (pert && n == 2) start[w] = 1'b1;
        if (pert && n == 3) start[w] = 1'b0;
        tick();
        n++;
      end
    end
    chk({tag, "_lat"}, seen ? 32'(n) : 32'hDEAD, 32'(nw(w)));
    chk({tag, "_o"}, 32'(o_of(w)), 32'(exp));
    chk({tag, "_busy_done"}, 32'(busy_v[w]), 32'd1);
    tick();
    chk({tag, "_done_off"}, 32'(done_v[w]), 32'd0);
    chk({tag, "_idle"}, 32'(busy_v[w]), 32'd0);
    chk({tag, "_o_hold"}, 32'(o_of(w)), 32'(exp));
    if (pert) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        chk({tag, "_no_extra"}, 32'(done_v[w]), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] words;
    int          last;
    int          cnt;
    words = 32'hD4C3B2A1;

    tick();
    tick();
    chk("rst_o4", 32'(o4), 32'd0);
    chk("rst_busy", 32'(busy_v), 32'd0);
    chk("rst_done", 32'(done_v), 32'd0);
    rst = 1'b0;
    tick();

    run(0, words, 2'd2, 1'b0, "t1");
    run(0, words, 2'd0, 1'b0, "t2_e0");
    run(0, words, 2'd3, 1'b0, "t2_e3");
    run(0, words, 2'd2, 1'b1, "t3");

    g = words;
    e = 2'd2;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("t4_o", 32'(o4), 32'd0);
    chk("t4_busy", 32'(busy_v[0]), 32'd0);
    chk("t4_done", 32'(done_v[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_no_done", 32'(done_v[0]), 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_no_done_rel", 32'(done_v[0]), 32'd0);
    end
    run(0, words, 2'd1, 1'b0, "t4_after");

    run(1, 32'h0033_2211, 2'd3, 1'b0, "t5_n3_e3");
    run(1, 32'h0033_2211, 2'd1, 1'b0, "t5_n3_e1");
    run(2, 32'h0000_005A, 2'd0, 1'b0, "t5_n1_e0");
    run(2, 32'h0000_00C7, 2'd1, 1'b0, "t5_n1_e1");

    for (int r = 0; r < 12; r++) begin
      run($urandom_range(0, 2), $urandom, 2'($urandom_range(0, 3)),
          1'b0, "rand");
    end

    g = words;
    e = 2'd1;
    start[0] = 1'b1;
    last = -1;
    cnt = 0;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (done_v[0]) begin
        chk("t6_o", 32'(o4), 32'hB2);
        if (last < 0) chk("t6_first", 32'(c), 32'd4);
        else          chk("t6_gap", 32'(c - last), 32'd5);
        last = c;
        cnt++;
      end else if (last > 0) begin
        chk("t6_hold", 32'(o4), 32'hB2);
      end
    end
    chk("t6_count", 32'(cnt), 32'd5);
    start[0] = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("t6_idle", 32'(busy_v[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
